// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_e    : fetch FSM state encoding
//   RESET_PC_DEFAULT : default PC loaded on reset
//   PC_INC_DEFAULT   : default byte step between sequential fetches
//   NOP_INSTR        : zero instruction used as the bubble value
package fetch_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC_DEFAULT   = 32'd4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
endpackage

// File: rtl/fetch_pc_register.sv
// Program counter register.
//   clk, rst     : clock, async active-high reset (loads RESET_PC)
//   inc_en       : advance to pc + PC_INC
//   load_en      : load load_addr (wins over inc_en)
//   load_addr    : redirect address
//   pc           : current PC
//   pc_seq       : pc + PC_INC (32-bit wrap)
module pc_register
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_INC   = PC_INC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_en,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_seq
);
  logic [31:0] pc_q, pc_d;

  assign pc_seq = pc_q + PC_INC;
  assign pc     = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_en)     pc_d = load_addr;
    else if (inc_en) pc_d = pc_seq;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a req/ack imem handshake and
// feeds the IF/ID register with {PC+PC_INC, instruction}, write and flush.
//   clk, rst                     : clock, async active-high reset
//   stall                        : hold PC and IF/ID this cycle
//   branch_taken, branch_target  : redirect from ID (highest priority)
//   imem_req, imem_addr          : level request, address = PC
//   imem_ack, imem_rdata         : one-cycle response pulse + data
//   if_id_pc, if_id_instr        : delivered PC+PC_INC / instruction (0 otherwise)
//   if_id_write, if_id_flush     : IF/ID write enable / bubble insert
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_INC   = PC_INC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_write,
  output logic        if_id_flush
);
  fetch_state_e state_q, state_d;
  logic [31:0]  hold_q, hold_d;
  logic [31:0]  pc, pc_seq;
  logic         deliver, from_hold;

  pc_register #(.RESET_PC(RESET_PC), .PC_INC(PC_INC)) u_pc (
    .clk       (clk),
    .rst       (rst),
    .inc_en    (deliver),
    .load_en   (branch_taken),
    .load_addr (branch_target),
    .pc        (pc),
    .pc_seq    (pc_seq)
  );

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    deliver   = 1'b0;
    from_hold = 1'b0;
    imem_req  = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          // Without an ack the response still in flight is for the old PC.
          state_d = imem_ack ? S_REQ : S_DRAIN;
        end else if (imem_ack) begin
          if (stall) begin
            hold_d  = imem_rdata;
            state_d = S_HOLD;
          end else begin
            deliver = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          hold_d  = NOP_INSTR;
          state_d = S_REQ;
        end else if (!stall) begin
          deliver   = 1'b1;
          from_hold = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_DRAIN: begin
        // The stale ack retires the old request even alongside a new redirect.
        if (imem_ack) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hold_q  <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign imem_addr   = pc;
  // Gated by rst so IF/ID sees neither write nor flush while in reset.
  assign if_id_write = !rst && deliver;
  assign if_id_flush = !rst && (branch_taken || (!stall && !deliver));
  assign if_id_pc    = deliver ? pc_seq : 32'h0;
  assign if_id_instr = deliver ? (from_hold ? hold_q : imem_rdata) : NOP_INSTR;
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_write;
  logic        if_id_flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge; outputs settle 1 time unit later.
  task automatic cyc(input logic st, input logic br, input logic [31:0] tgt,
                     input logic ack, input logic [31:0] rd);
    @(negedge clk);
    stall = st; branch_taken = br; branch_target = tgt;
    imem_ack = ack; imem_rdata = rd;
    #1;
  endtask

  // Expectations for the current cycle.
  task automatic exp_out(input string tag, input logic [31:0] addr, input logic req,
                         input logic wr, input logic fl,
                         input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, ".addr"},  imem_addr,   addr);
    chk({tag, ".req"},   imem_req,    req);
    chk({tag, ".write"}, if_id_write, wr);
    chk({tag, ".flush"}, if_id_flush, fl);
    chk({tag, ".pc"},    if_id_pc,    pc);
    chk({tag, ".instr"}, if_id_instr, ins);
  endtask

  task automatic do_reset(input string tag);
    cyc(0, 0, 32'h0, 0, 32'h0);
    rst = 1'b1;
    #1;
    exp_out({tag, ".rst"}, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    // IDLE: no request, bubble into IF/ID.
    exp_out({tag, ".idle"}, 32'h0, 0, 0, 1, 32'h0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // 1) zero-wait memory, back-to-back.
    do_reset("t1");
    cyc(0, 0, 32'h0, 1, 32'h1111_0000);
    exp_out("t1.f0", 32'h0, 1, 1, 0, 32'h4, 32'h1111_0000);
    cyc(0, 0, 32'h0, 1, 32'h1111_0004);
    exp_out("t1.f4", 32'h4, 1, 1, 0, 32'h8, 32'h1111_0004);
    cyc(0, 0, 32'h0, 1, 32'h1111_0008);
    exp_out("t1.f8", 32'h8, 1, 1, 0, 32'hC, 32'h1111_0008);

    // 2) three-cycle ack delay at addr 0.
    do_reset("t2");
    cyc(0, 0, 32'h0, 0, 32'hDEAD_BEEF);
    exp_out("t2.w1", 32'h0, 1, 0, 1, 32'h0, 32'h0);
    cyc(0, 0, 32'h0, 0, 32'hDEAD_BEEF);
    exp_out("t2.w2", 32'h0, 1, 0, 1, 32'h0, 32'h0);
    cyc(0, 0, 32'h0, 1, 32'h2222_0000);
    exp_out("t2.ack", 32'h0, 1, 1, 0, 32'h4, 32'h2222_0000);

    // 3) stall on the ack of addr 8, held two cycles.
    cyc(0, 0, 32'h0, 1, 32'h2222_0004);
    exp_out("t3.f4", 32'h4, 1, 1, 0, 32'h8, 32'h2222_0004);
    cyc(1, 0, 32'h0, 1, 32'h8C22_0004);
    exp_out("t3.cap", 32'h8, 1, 0, 0, 32'h0, 32'h0);
    cyc(1, 0, 32'h0, 0, 32'h0);
    exp_out("t3.hold", 32'h8, 0, 0, 0, 32'h0, 32'h0);
    cyc(0, 0, 32'h0, 0, 32'h5555_5555);
    exp_out("t3.rel", 32'h8, 0, 1, 0, 32'hC, 32'h8C22_0004);
    cyc(0, 0, 32'h0, 0, 32'h0);
    exp_out("t3.next", 32'hC, 1, 0, 1, 32'h0, 32'h0);
    cyc(0, 0, 32'h0, 1, 32'h2222_000C);
    exp_out("t3.fC", 32'hC, 1, 1, 0, 32'h10, 32'h2222_000C);

    // 4) redirect while request to 0x10 outstanding; stale ack two cycles later.
    cyc(0, 1, 32'h100, 0, 32'h0);
    exp_out("t4.br", 32'h10, 1, 0, 1, 32'h0, 32'h0);
    cyc(0, 0, 32'h0, 0, 32'h0);
    exp_out("t4.drn", 32'h100, 0, 0, 1, 32'h0, 32'h0);
    cyc(0, 0, 32'h0, 1, 32'hBAD0_0010);
    exp_out("t4.stale", 32'h100, 0, 0, 1, 32'h0, 32'h0);
    cyc(0, 0, 32'h0, 1, 32'h3333_0100);
    exp_out("t4.f100", 32'h100, 1, 1, 0, 32'h104, 32'h3333_0100);

    // 5) branch + stall together on an ack cycle.
    cyc(1, 1, 32'h200, 1, 32'hBAD0_0104);
    exp_out("t5.br", 32'h104, 1, 0, 1, 32'h0, 32'h0);
    cyc(0, 0, 32'h0, 0, 32'h0);
    exp_out("t5.req", 32'h200, 1, 0, 1, 32'h0, 32'h0);
    cyc(0, 0, 32'h0, 1, 32'h4444_0200);
    exp_out("t5.f200", 32'h200, 1, 1, 0, 32'h204, 32'h4444_0200);

    // 6) PC wrap, then async reset mid-wait.
    cyc(0, 1, 32'hFFFF_FFFC, 1, 32'hBAD0_0204);
    exp_out("t6.br", 32'h204, 1, 0, 1, 32'h0, 32'h0);
    cyc(0, 0, 32'h0, 1, 32'h5555_FFFC);
    exp_out("t6.wrap", 32'hFFFF_FFFC, 1, 1, 0, 32'h0, 32'h5555_FFFC);
    cyc(0, 0, 32'h0, 1, 32'h6666_0000);
    exp_out("t6.f0", 32'h0, 1, 1, 0, 32'h4, 32'h6666_0000);
    cyc(0, 0, 32'h0, 0, 32'h0);
    exp_out("t6.wait", 32'h4, 1, 0, 1, 32'h0, 32'h0);
    #2 rst = 1'b1;
    #1;
    exp_out("t6.arst", 32'h0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_out("t6.idle", 32'h0, 0, 0, 1, 32'h0, 32'h0);
    cyc(0, 0, 32'h0, 1, 32'h7777_0000);
    exp_out("t6.restart", 32'h0, 1, 1, 0, 32'h4, 32'h7777_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage pipeline; the producer side of the IF/ID pipeline register.
- Owns the PC and drives a variable-latency instruction-memory request/acknowledge interface.
- Presents {PC+4, instruction} to IF/ID together with its write-enable and flush.
- Takes stall from the hazard unit and branch redirect from ID. Guarantees that IF/ID only ever sees a valid in-order instruction, a bubble (flush), or a hold.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_INC, 4, byte increment between sequential fetches.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID this cycle.
- branch_taken  in  1  ID: redirect fetch this cycle.
- branch_target  in  32  redirect address, valid with branch_taken.
- imem_req  out  1  memory request, level, held until acknowledged.
- imem_addr  out  32  fetch address, equals current PC.
- imem_ack  in  1  one-cycle pulse: imem_rdata valid, request retired.
- imem_rdata  in  32  fetched instruction.
- if_id_pc  out  32  PC+PC_INC of the delivered instruction; drives IF/ID PCIn.
- if_id_instr  out  32  delivered instruction; drives IF/ID instructionIn.
- if_id_write  out  1  IF/ID write enable.
- if_id_flush  out  1  IF/ID flush (zero-instruction bubble).

Behaviour:
- Reset (async):
  - pc=RESET_PC, state=IDLE, hold buffer=0.
  - Outputs: imem_req=0, imem_addr=RESET_PC, if_id_write=0, if_id_flush=0, if_id_pc=0, if_id_instr=0.
  - The memory shares rst, so any outstanding request is dropped.
- States:
  - IDLE: one cycle after reset release, no request, then REQ.
  - REQ: imem_req=1, imem_addr=pc.
  - HOLD: instruction captured, waiting for stall release.
  - DRAIN: discarding a stale in-flight response after a redirect.
- Deliver condition:
  - REQ & imem_ack & !stall & !branch_taken: outputs come from imem_rdata, pc+PC_INC.
  - HOLD & !stall & !branch_taken: outputs come from the hold buffer, pc+PC_INC.
- Deliver cycle:
  - if_id_write=1.
  - pc <= pc+PC_INC with 32-bit wrap (32'hFFFF_FFFC -> 32'h0).
  - Next state REQ; back-to-back requests are allowed, and imem_req stays 1.
- Output rules (combinational):
  - if_id_write = deliver.
  - if_id_flush = branch_taken | (!stall & !deliver).
  - When neither writing nor flushing (stall), IF/ID holds its contents.
  - if_id_pc / if_id_instr = 0 when not delivering.
- REQ & imem_ack & stall & !branch_taken: capture rdata into the hold buffer, go to HOLD, no write, no flush.
- branch_taken has priority over stall and delivery:
  - pc <= branch_target, if_id_flush=1, if_id_write=0.
  - In REQ without ack this cycle: go to DRAIN (the response in flight belongs to the old PC).
  - In REQ with ack this cycle: discard the data, go to REQ.
  - In HOLD: discard the buffer, go to REQ.
  - In DRAIN: stay in DRAIN with the new pc.
  - In IDLE: go to REQ.
- DRAIN:
  - imem_req=0.
  - On imem_ack: discard, go to REQ.
  - Flushes IF/ID each non-stall cycle.
- Latency: the minimum fetch-to-IF/ID latency is one cycle after ack (IF/ID captures on the ack edge). Sustained throughput is one instruction per cycle with a zero-wait memory.
- imem_addr always equals pc; it is stable while imem_req=1 and no redirect occurs.
- imem_ack outside REQ/DRAIN is ignored. In DRAIN, an ack that coincides with branch_taken retires the stale request.

Decomposition:
- Shared pipeline package holds:
  - fetch state encoding (IDLE, REQ, HOLD, DRAIN).
  - RESET_PC and PC_INC defaults.
  - NOP instruction constant 32'h0.
- One natural sub-module, pc_register: a 32-bit register with async reset to RESET_PC and load-enable/mux between pc+PC_INC and branch_target.
- FSM and hold buffer stay in fetch_unit.

Test Plan:
- Reset, zero-wait memory (ack the cycle after req), no stall -> imem_addr 0x0,0x4,0x8; if_id_pc 0x4,0x8,0xC each cycle, write=1, flush=0.
- Memory with a 3-cycle ack delay -> imem_addr held at 0x0 for 3 cycles; if_id_flush=1 on the two non-ack cycles; write=1 with if_id_pc=0x4 on the ack cycle.
- Stall asserted on the ack cycle of addr 0x8 (rdata 0x8C220004) for 2 cycles -> HOLD, write=0, flush=0; on release, write=1, if_id_instr=0x8C220004, if_id_pc=0xC, next imem_addr 0xC.
- branch_taken to 0x100 while the request to 0x10 is outstanding, ack 2 cycles later -> flush=1 that cycle, stale rdata never written; next request imem_addr=0x100, then if_id_pc=0x104.
- branch_taken and stall together on an ack cycle -> flush=1, write=0, data discarded, next imem_addr=branch_target.
- pc=0xFFFF_FFFC with a zero-wait ack -> if_id_pc=0x0, next imem_addr=0x0; async rst mid-wait -> outputs zeroed immediately, fetch restarts at RESET_PC.
